// File: rtl/adder_pkg.sv
// Shared definitions for the sliced accumulator: slice width, FSM states and
// the sizing helper for the slice index.
package adder_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } acc_state_e;

    // A single-slice datapath still needs a 1-bit index register.
    function automatic int idx_width(input int num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/adder_accumulator_if.sv
// Operand handshake and result bus of the accumulator; the producer side is
// the master, the accumulator the slave.
interface adder_accumulator_if #(
    parameter int ACC_W = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;
    logic             in_clear;
    logic [ACC_W-1:0] acc_out;
    logic             acc_ovf;
    logic             out_valid;

    modport master (
        output in_valid, in_data, in_clear,
        input  in_ready, acc_out, acc_ovf, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_clear,
        output in_ready, acc_out, acc_ovf, out_valid
    );
endinterface

// File: rtl/rtl_16bit_adder.sv
// Combinational 16-bit adder with carry in and carry out.
module rtl_16bit_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

// File: rtl/adder_accumulator.sv
// Multi-precision accumulator: each accepted operand is added into the running
// sum one 16-bit slice per cycle through a single shared adder.
module adder_accumulator
    import adder_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_accumulator_if.slave   bus
);
    localparam int NUM_SLICES = ACC_W / SLICE_W;
    localparam int IDX_W      = idx_width(NUM_SLICES);

    generate
        if ((ACC_W % SLICE_W) != 0 || ACC_W < 16 || ACC_W > 64) begin : g_bad_width
            $error("adder_accumulator: ACC_W must be a multiple of 16 in 16..64");
        end
    endgenerate

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] op_q, op_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_cout;
    logic               last_slice;

    assign slice_a    = acc_q[int'(idx_q) * SLICE_W +: SLICE_W];
    assign slice_b    = op_q[int'(idx_q) * SLICE_W +: SLICE_W];
    assign last_slice = (idx_q == IDX_W'(NUM_SLICES - 1));

    rtl_16bit_adder u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.in_data;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ADD;
                    if (bus.in_clear) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end
                end
            end
            ADD: begin
                acc_d[int'(idx_q) * SLICE_W +: SLICE_W] = slice_s;
                carry_d = slice_cout;
                if (last_slice) begin
                    ovf_d       = ovf_q | slice_cout;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready comes straight from the state register, so no input reaches an output.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.acc_out   = acc_q;
    assign bus.acc_ovf   = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// Scoreboard bench for adder_accumulator at ACC_W=32 and ACC_W=16.
module tb_adder_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] acc;
        logic        ovf;
        int          t;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int   last_pulse32 = -1;
    bit   spacing_en   = 1'b0;

    adder_accumulator_if #(.ACC_W(32)) bus32 ();
    adder_accumulator_if #(.ACC_W(16)) bus16 ();

    adder_accumulator #(.ACC_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    adder_accumulator #(.ACC_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (bus32.out_valid === 1'b1) begin
            if (q32.size() == 0) begin
                chk("unexpected_pulse32", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                chk("acc32", 64'(bus32.acc_out), e.acc);
                chk("ovf32", 64'(bus32.acc_ovf), 64'(e.ovf));
                chk("latency32", 64'(cyc - e.t), 64'd2);
                chk("ready_on_pulse32", 64'(bus32.in_ready), 64'd1);
                if (spacing_en && last_pulse32 >= 0)
                    chk("spacing32", 64'(cyc - last_pulse32), 64'd3);
                last_pulse32 = cyc;
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (bus16.out_valid === 1'b1) begin
            if (q16.size() == 0) begin
                chk("unexpected_pulse16", 64'd1, 64'd0);
            end else begin
                e = q16.pop_front();
                chk("acc16", 64'(bus16.acc_out), e.acc);
                chk("ovf16", 64'(bus16.acc_ovf), 64'(e.ovf));
                chk("latency16", 64'(cyc - e.t), 64'd1);
            end
        end
    end

    task automatic send32(input logic [31:0] d, input logic clr,
                          input logic [31:0] ea, input logic eo);
        int n = 0;
        @(negedge clk);
        bus32.in_valid = 1'b1;
        bus32.in_data  = d;
        bus32.in_clear = clr;
        while (bus32.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout32", 64'd0, 64'd1);
            return;
        end
        q32.push_back('{acc: 64'(ea), ovf: eo, t: cyc + 1});
        @(posedge clk);
        @(negedge clk);
        chk("busy_ready32", 64'(bus32.in_ready), 64'd0);
    endtask

    task automatic send16(input logic [15:0] d, input logic clr,
                          input logic [15:0] ea, input logic eo);
        int n = 0;
        @(negedge clk);
        bus16.in_valid = 1'b1;
        bus16.in_data  = d;
        bus16.in_clear = clr;
        while (bus16.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout16", 64'd0, 64'd1);
            return;
        end
        q16.push_back('{acc: 64'(ea), ovf: eo, t: cyc + 1});
        @(posedge clk);
        @(negedge clk);
        chk("busy_ready16", 64'(bus16.in_ready), 64'd0);
    endtask

    task automatic idle_all();
        @(negedge clk);
        bus32.in_valid = 1'b0;
        bus32.in_clear = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.in_clear = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("drain_timeout", 64'(q32.size() + q16.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus32.in_valid = 1'b0;
        bus32.in_data  = '0;
        bus32.in_clear = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.in_data  = '0;
        bus16.in_clear = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_acc32", 64'(bus32.acc_out), 64'd0);
        chk("rst_ovf32", 64'(bus32.acc_ovf), 64'd0);
        chk("rst_valid32", 64'(bus32.out_valid), 64'd0);
        chk("rst_ready32", 64'(bus32.in_ready), 64'd1);
        chk("rst_acc16", 64'(bus16.acc_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready32", 64'(bus32.in_ready), 64'd1);

        // Carry from slice 0 into slice 1
        send32(32'h0000_FFFF, 1'b1, 32'h0000_FFFF, 1'b0);
        send32(32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0);
        idle_all();
        drain();

        // Overflow is sticky until a clearing operand
        send32(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);
        send32(32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        send32(32'h0000_0005, 1'b0, 32'h0000_0005, 1'b1);
        send32(32'h0000_0007, 1'b1, 32'h0000_0007, 1'b0);
        idle_all();
        drain();

        // in_valid held high across three operands
        spacing_en   = 1'b1;
        last_pulse32 = -1;
        send32(32'd1, 1'b1, 32'd1, 1'b0);
        send32(32'd2, 1'b0, 32'd3, 1'b0);
        send32(32'd3, 1'b0, 32'd6, 1'b0);
        idle_all();
        drain();
        spacing_en = 1'b0;
        chk("hold_acc32", 64'(bus32.acc_out), 64'd6);

        // Asynchronous reset during slice 1 aborts the operand
        @(negedge clk);
        bus32.in_valid = 1'b1;
        bus32.in_data  = 32'h1234_5678;
        bus32.in_clear = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("partial_acc32", 64'(bus32.acc_out), 64'h0000_5678);
        #1;
        bus32.in_valid = 1'b0;
        bus32.in_clear = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_acc32", 64'(bus32.acc_out), 64'd0);
        chk("abort_ovf32", 64'(bus32.acc_ovf), 64'd0);
        chk("abort_valid32", 64'(bus32.out_valid), 64'd0);
        chk("abort_ready32", 64'(bus32.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send32(32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0);
        idle_all();
        drain();

        // Single-slice configuration
        send16(16'hFFFF, 1'b1, 16'hFFFF, 1'b0);
        send16(16'h0001, 1'b0, 16'h0000, 1'b1);
        idle_all();
        drain();
        chk("hold_ovf16", 64'(bus16.acc_ovf), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
